// File: rtl/core_sequencer_if.sv
// Datapath-facing bundle of the core sequencer: stage strobes, opcode feed
// and data-memory request/acknowledge handshake.
interface core_sequencer_if #(
  parameter int unsigned OPCODE_WIDTH = 5
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    mem_ack;
  logic                    ir_we;
  logic                    pc_we;
  logic                    rf_rd_en;
  logic                    alu_en;
  logic                    mem_req;
  logic                    mem_we;
  logic                    rf_we;

  modport master (
    input  opcode, mem_ack,
    output ir_we, pc_we, rf_rd_en, alu_en, mem_req, mem_we, rf_we
  );

  modport slave (
    output opcode, mem_ack,
    input  ir_we, pc_we, rf_rd_en, alu_en, mem_req, mem_we, rf_we
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: per-stage datapath strobes, run/step/halt control,
// data-memory handshake with timeout and a retired-instruction counter.
module core_sequencer #(
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OP = 5'h1F,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter logic [OPCODE_WIDTH-1:0] OP_BR   = 5'h00,
  parameter logic [OPCODE_WIDTH-1:0] OP_LD   = 5'h02,
  parameter logic [OPCODE_WIDTH-1:0] OP_ST   = 5'h03,
  parameter logic [OPCODE_WIDTH-1:0] OP_JSR  = 5'h04,
  parameter logic [OPCODE_WIDTH-1:0] OP_JMP  = 5'h0C,
  parameter logic [OPCODE_WIDTH-1:0] OP_JSRR = 5'h0D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 step,
  input  logic                 resume,
  core_sequencer_if.master     bus,
  output logic                 busy,
  output logic                 halted,
  output logic                 mem_fault,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [WAIT_W-1:0]       wait_q;
  logic                    retire;
  logic                    timeout;
  logic                    is_ld, is_st, is_br, is_jmp, is_jsr, is_jsrr;

  logic ir_we, pc_we, rf_rd_en, alu_en, mem_req, mem_we, rf_we;

  assign is_ld   = (op_q == OP_LD);
  assign is_st   = (op_q == OP_ST);
  assign is_br   = (op_q == OP_BR);
  assign is_jmp  = (op_q == OP_JMP);
  assign is_jsr  = (op_q == OP_JSR);
  assign is_jsrr = (op_q == OP_JSRR);

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    timeout  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_rd_en = 1'b0;
    alu_en   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        rf_rd_en = 1'b1;
        state_d  = (bus.opcode == HALT_OP) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        pc_we  = is_br | is_jmp | is_jsr | is_jsrr;
        if (is_ld || is_st)      state_d = S_MEM;
        else if (is_br || is_jmp) retire = 1'b1;
        else                      state_d = S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_st;
        // A late ack on the final wait cycle still completes normally.
        if (bus.mem_ack) begin
          if (is_st) retire  = 1'b1;
          else       state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_HALT: begin
        if (resume) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      wait_q      <= '0;
      instr_count <= '0;
      mem_fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (state_q == S_MEM && state_d == S_MEM) wait_q <= wait_q + 1'b1;
      else                                      wait_q <= '0;
      if (retire) instr_count <= instr_count + 1'b1;
      if (timeout)                           mem_fault <= 1'b1;
      else if (state_q == S_HALT && resume)  mem_fault <= 1'b0;
    end
  end

  assign bus.ir_we    = ir_we;
  assign bus.pc_we    = pc_we;
  assign bus.rf_rd_en = rf_rd_en;
  assign bus.alu_en   = alu_en;
  assign bus.mem_req  = mem_req;
  assign bus.mem_we   = mem_we;
  assign bus.rf_we    = rf_we;

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);
  assign state  = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomised, self-checking bench for core_sequencer; a per-instruction stage
// model predicts state, strobes and the retired count every cycle.
module tb_core_sequencer;

  localparam logic [4:0] OP_BR   = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_LD   = 5'h02;
  localparam logic [4:0] OP_ST   = 5'h03;
  localparam logic [4:0] OP_JSR  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_NOT  = 5'h09;
  localparam logic [4:0] OP_JMP  = 5'h0C;
  localparam logic [4:0] OP_JSRR = 5'h0D;
  localparam logic [4:0] OP_MOV  = 5'h0E;
  localparam logic [4:0] HALT_OP = 5'h1F;
  localparam int MEM_TIMEOUT = 16;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  // strobe vector order: ir_we pc_we rf_rd_en alu_en mem_req mem_we rf_we busy halted
  localparam logic [8:0] V_IDLE   = 9'b000000000;
  localparam logic [8:0] V_FETCH  = 9'b110000010;
  localparam logic [8:0] V_DECODE = 9'b001000010;
  localparam logic [8:0] V_WB     = 9'b000000110;
  localparam logic [8:0] V_HALT   = 9'b000000001;

  logic clk = 1'b0;
  logic rst_n, run, step, resume, mem_ack;
  logic [4:0] opcode;
  logic busy16, halted16, fault16, busy4, halted4, fault4;
  logic [2:0] st16, st4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  core_sequencer_if #(.OPCODE_WIDTH(5)) if16 ();
  core_sequencer_if #(.OPCODE_WIDTH(5)) if4 ();

  assign if16.opcode  = opcode;
  assign if16.mem_ack = mem_ack;
  assign if4.opcode   = opcode;
  assign if4.mem_ack  = mem_ack;

  core_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .resume(resume),
    .bus(if16), .busy(busy16), .halted(halted16), .mem_fault(fault16),
    .state(st16), .instr_count(cnt16)
  );

  core_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .resume(resume),
    .bus(if4), .busy(busy4), .halted(halted4), .mem_fault(fault4),
    .state(st4), .instr_count(cnt4)
  );

  logic [8:0] v16, v4;
  assign v16 = {if16.ir_we, if16.pc_we, if16.rf_rd_en, if16.alu_en, if16.mem_req,
                if16.mem_we, if16.rf_we, busy16, halted16};
  assign v4  = {if4.ir_we, if4.pc_we, if4.rf_rd_en, if4.alu_en, if4.mem_req,
                if4.mem_we, if4.rf_we, busy4, halted4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [2:0] es, input logic [8:0] ev);
    chk({tag, "_state"}, {29'd0, st16}, {29'd0, es});
    chk({tag, "_strobes"}, {23'd0, v16}, {23'd0, ev});
    chk({tag, "_cw4"}, {20'd0, st4, v4}, {20'd0, es, ev});
  endtask

  task automatic chk_count(input string tag);
    chk({tag, "_cnt16"}, {16'd0, cnt16}, model_cnt & 32'hFFFF);
    chk({tag, "_cnt4"}, {28'd0, cnt4}, model_cnt & 32'hF);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit use_step);
    if (use_step) begin run = 1'b0; step = 1'b1; end
    else run = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic retire_chk(input bit keep_run);
    model_cnt++;
    step = 1'b0;
    chk_cyc("retire", keep_run ? S_FETCH : S_IDLE, keep_run ? V_FETCH : V_IDLE);
    chk_count("retire");
  endtask

  // Precondition: sequencer has just entered FETCH. Step is toggled at random
  // throughout to confirm it is ignored while busy.
  task automatic do_instr(input logic [4:0] op, input int ack_dly, input bit keep_run);
    bit br_pc, ret_exec, is_mem, is_st, acked;
    br_pc    = op inside {OP_BR, OP_JMP, OP_JSR, OP_JSRR};
    ret_exec = op inside {OP_BR, OP_JMP};
    is_mem   = op inside {OP_LD, OP_ST};
    is_st    = (op == OP_ST);
    acked    = 1'b0;
    opcode   = op;
    chk_cyc("fetch", S_FETCH, V_FETCH);
    run  = keep_run;
    step = 1'($urandom_range(0, 1));
    tick();
    chk_cyc("decode", S_DECODE, V_DECODE);
    step = 1'($urandom_range(0, 1));
    tick();
    if (op == HALT_OP) begin
      step = 1'b0;
      chk_cyc("halt_op", S_HALT, V_HALT);
      chk_count("halt_op");
      return;
    end
    chk_cyc("exec", S_EXEC, {1'b0, br_pc, 2'b01, 3'b000, 2'b10});
    step = 1'($urandom_range(0, 1));
    tick();
    if (ret_exec) begin
      retire_chk(keep_run);
      return;
    end
    if (is_mem) begin
      for (int w = 0; w < MEM_TIMEOUT && !acked; w++) begin
        mem_ack = (w == ack_dly);
        chk_cyc("mem", S_MEM, {4'b0000, 1'b1, is_st, 1'b0, 2'b10});
        step = 1'($urandom_range(0, 1));
        tick();
        acked   = mem_ack;
        mem_ack = 1'b0;
      end
      if (!acked) begin
        step = 1'b0;
        chk_cyc("timeout", S_HALT, V_HALT);
        chk("timeout_fault", {31'd0, fault16}, 32'd1);
        chk_count("timeout");
        return;
      end
      if (is_st) begin
        retire_chk(keep_run);
        return;
      end
    end
    chk_cyc("wb", S_WB, V_WB);
    step = 1'($urandom_range(0, 1));
    tick();
    retire_chk(keep_run);
  endtask

  // In HALT: run/step must be ignored; resume returns to IDLE clearing the fault.
  task automatic halt_hold(input bit exp_fault);
    run = 1'b1; step = 1'b1;
    tick();
    chk_cyc("halt_ignore", S_HALT, V_HALT);
    chk("halt_fault", {31'd0, fault16}, {31'd0, exp_fault});
    run = 1'b0; step = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0;
    chk_cyc("resume", S_IDLE, V_IDLE);
    chk("resume_fault", {31'd0, fault16}, 32'd0);
    chk_count("resume");
  endtask

  initial begin
    logic [4:0] ops [10];
    bit at_fetch, use_step, keep;
    ops = '{OP_ADD, OP_AND, OP_MOV, OP_NOT, OP_BR, OP_JMP, OP_JSR, OP_JSRR, OP_LD, OP_ST};
    rst_n = 1'b0; run = 1'b0; step = 1'b0; resume = 1'b0; mem_ack = 1'b0; opcode = OP_ADD;
    #12;
    chk_cyc("in_reset", S_IDLE, V_IDLE);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_cyc("reset", S_IDLE, V_IDLE);
    chk_count("reset");
    chk("reset_fault", {31'd0, fault16}, 32'd0);

    // ADD, AND, LD, ST back to back with immediate ack
    start(1'b0);
    do_instr(OP_ADD, 0, 1'b1);
    do_instr(OP_AND, 0, 1'b1);
    do_instr(OP_LD, 0, 1'b1);
    do_instr(OP_ST, 0, 1'b0);
    chk("four_retired", {16'd0, cnt16}, 32'd4);

    // single step on a branch
    start(1'b1);
    do_instr(OP_BR, 0, 1'b0);

    // LD with three wait cycles
    start(1'b0);
    do_instr(OP_LD, 3, 1'b0);

    // LD that never gets an ack
    start(1'b1);
    do_instr(OP_LD, 99, 1'b0);
    halt_hold(1'b1);

    // halt opcode with run held
    start(1'b0);
    do_instr(HALT_OP, 0, 1'b1);
    halt_hold(1'b0);

    // asynchronous reset in the middle of a memory request
    start(1'b0);
    opcode = OP_LD; run = 1'b0; mem_ack = 1'b0;
    tick(); tick(); tick();
    chk_cyc("pre_rst_mem", S_MEM, 9'b000010010);
    #2 rst_n = 1'b0;
    #1;
    model_cnt = 0;
    chk_cyc("async_rst", S_IDLE, V_IDLE);
    chk_count("async_rst");
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_cyc("post_rst", S_IDLE, V_IDLE);
    chk_count("post_rst");

    // 17 ADDs wrap a 4-bit counter to 1
    start(1'b0);
    for (int i = 0; i < 17; i++) do_instr(OP_ADD, 0, (i != 16));
    chk("wrap4", {28'd0, cnt4}, 32'd1);
    chk("wrap16", {16'd0, cnt16}, 32'd17);

    // random mix
    at_fetch = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!at_fetch) begin
        use_step = 1'($urandom_range(0, 1));
        start(use_step);
        keep = use_step ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        keep = 1'($urandom_range(0, 1));
      end
      do_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 4), keep);
      at_fetch = keep;
    end
    if (at_fetch) begin
      do_instr(OP_ADD, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
